// File: rtl/pic_params.sv
// rtl/pic_params.sv - shared sizing, addresses and FSM encoding for the banked file register
package pic_params;
  localparam int DWIDTH           = 8;
  localparam int NUM_FREGS        = 32;
  localparam int L2_NUM_FREG      = 5;
  localparam int NUM_BANKS        = 2;
  localparam int L2_NUM_BANKS     = 1;
  localparam int NUM_SHARED       = 16;
  localparam int NUM_EXPOSED_REGS = 4;
  localparam int INDF_REG_ADDR    = 0;
  localparam int FSR_REG_ADDR     = 4;
  localparam int EXPOSED_BASE     = 16;

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_RUN   = 1'b1
  } state_t;
endpackage

// File: rtl/reg_file_addr_map.sv
// rtl/reg_file_addr_map.sv - resolves direct/indirect access into a physical index and flags
module reg_file_addr_map #(
  parameter int L2_NUM_FREG      = pic_params::L2_NUM_FREG,
  parameter int L2_NUM_BANKS     = pic_params::L2_NUM_BANKS,
  parameter int NUM_SHARED       = pic_params::NUM_SHARED,
  parameter int NUM_EXPOSED_REGS = pic_params::NUM_EXPOSED_REGS,
  parameter int INDF_REG_ADDR    = pic_params::INDF_REG_ADDR,
  parameter int EXW              = 2
) (
  input  logic [L2_NUM_FREG-1:0]              addr,
  input  logic [L2_NUM_BANKS-1:0]             bank_i,
  input  logic [L2_NUM_FREG+L2_NUM_BANKS-1:0] fsr,
  output logic [L2_NUM_FREG+L2_NUM_BANKS-1:0] phys_idx,
  output logic                                is_indf_self,
  output logic                                exposed_hit,
  output logic [EXW-1:0]                      exposed_idx
);
  import pic_params::*;

  logic                    is_indf;
  logic [L2_NUM_FREG-1:0]  eff_addr;
  logic [L2_NUM_BANKS-1:0] sel_bank;
  logic [L2_NUM_BANKS-1:0] eff_bank;
  int                      eff_int;

  always_comb begin
    is_indf      = (addr == L2_NUM_FREG'(INDF_REG_ADDR));
    eff_addr     = is_indf ? fsr[L2_NUM_FREG-1:0] : addr;
    sel_bank     = is_indf ? fsr[L2_NUM_FREG +: L2_NUM_BANKS] : bank_i;
    eff_int      = int'(eff_addr);
    // The shared low region is checked after indirection so INDF honours it too.
    eff_bank     = (eff_int < NUM_SHARED) ? '0 : sel_bank;
    phys_idx     = {eff_bank, eff_addr};
    is_indf_self = is_indf && (eff_int == INDF_REG_ADDR);
    exposed_hit  = (eff_bank == '0) && (eff_int >= EXPOSED_BASE) &&
                   (eff_int < EXPOSED_BASE + NUM_EXPOSED_REGS);
    exposed_idx  = EXW'(eff_int - EXPOSED_BASE);
  end
endmodule

// File: rtl/reg_file_banked.sv
// rtl/reg_file_banked.sv - banked file register with clearing sweep; REG_FILE_FSR_POSTINC_EN adds FSR post-increment on INDF
module reg_file_banked #(
  parameter int DWIDTH           = pic_params::DWIDTH,
  parameter int NUM_FREGS        = pic_params::NUM_FREGS,
  parameter int L2_NUM_FREG      = pic_params::L2_NUM_FREG,
  parameter int NUM_BANKS        = pic_params::NUM_BANKS,
  parameter int L2_NUM_BANKS     = pic_params::L2_NUM_BANKS,
  parameter int NUM_SHARED       = pic_params::NUM_SHARED,
  parameter int NUM_EXPOSED_REGS = pic_params::NUM_EXPOSED_REGS,
  parameter int INDF_REG_ADDR    = pic_params::INDF_REG_ADDR,
  parameter int FSR_REG_ADDR     = pic_params::FSR_REG_ADDR
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic [L2_NUM_FREG-1:0]             addr,
  input  logic [L2_NUM_BANKS-1:0]            bank_i,
  input  logic [DWIDTH-1:0]                  data_bus_i,
  input  logic                               rden,
  input  logic                               wren,
  output logic [DWIDTH-1:0]                  data_bus_o,
  output logic                               rd_valid,
  output logic                               busy,
  input  logic [NUM_EXPOSED_REGS-1:0]        ext_wr,
  input  logic [DWIDTH*NUM_EXPOSED_REGS-1:0] ext_data,
  output logic [NUM_EXPOSED_REGS-1:0]        exposed_wr_strobe,
  output logic [DWIDTH*NUM_EXPOSED_REGS-1:0] exposed_reg_file
);
  import pic_params::*;

  localparam int DEPTH = NUM_BANKS * NUM_FREGS;
  localparam int IDXW  = L2_NUM_FREG + L2_NUM_BANKS;
  localparam int EXW   = (NUM_EXPOSED_REGS > 1) ? $clog2(NUM_EXPOSED_REGS) : 1;

  state_t            state, state_nxt;
  logic [IDXW-1:0]   clr_cnt;
  logic [DWIDTH-1:0] mem [DEPTH];
  logic [DWIDTH-1:0] fsr;
  logic [DWIDTH-1:0] rd_data;
  logic [IDXW-1:0]   phys_idx;
  logic [EXW-1:0]    exposed_idx;
  logic              is_indf_self, exposed_hit;
  logic              run, rd_acc, core_wr, fsr_wr;

  reg_file_addr_map #(
    .L2_NUM_FREG(L2_NUM_FREG), .L2_NUM_BANKS(L2_NUM_BANKS), .NUM_SHARED(NUM_SHARED),
    .NUM_EXPOSED_REGS(NUM_EXPOSED_REGS), .INDF_REG_ADDR(INDF_REG_ADDR), .EXW(EXW)
  ) u_addr_map (
    .addr(addr), .bank_i(bank_i), .fsr(fsr[IDXW-1:0]), .phys_idx(phys_idx),
    .is_indf_self(is_indf_self), .exposed_hit(exposed_hit), .exposed_idx(exposed_idx)
  );

  assign run     = (state == ST_RUN);
  assign busy    = !run;
  assign rd_acc  = run && rden;
  assign core_wr = run && wren && !is_indf_self;
  assign fsr_wr  = core_wr && (phys_idx == IDXW'(FSR_REG_ADDR));
  // FSR lives in its own flop so it resets asynchronously; its array slot is never read.
  assign rd_data = is_indf_self ? '0 :
                   (phys_idx == IDXW'(FSR_REG_ADDR)) ? fsr : mem[phys_idx];

`ifdef REG_FILE_FSR_POSTINC_EN
  logic            indf_acc;
  logic [IDXW-1:0] fsr_inc;
  assign indf_acc = run && (rden || wren) && (addr == L2_NUM_FREG'(INDF_REG_ADDR));
  assign fsr_inc  = fsr[IDXW-1:0] + 1'b1;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= ST_CLEAR;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_CLEAR: if (clr_cnt == IDXW'(DEPTH - 1)) state_nxt = ST_RUN;
      ST_RUN:   state_nxt = ST_RUN;
      default:  state_nxt = ST_CLEAR;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      clr_cnt           <= '0;
      fsr               <= '0;
      data_bus_o        <= '0;
      rd_valid          <= 1'b0;
      exposed_wr_strobe <= '0;
    end else begin
      rd_valid          <= rd_acc;
      exposed_wr_strobe <= '0;
      if (!run) clr_cnt <= clr_cnt + 1'b1;
      if (rd_acc) data_bus_o <= rd_data;
      if (core_wr && exposed_hit) exposed_wr_strobe[exposed_idx] <= 1'b1;
`ifdef REG_FILE_FSR_POSTINC_EN
      if (indf_acc) fsr <= DWIDTH'(fsr_inc);
`endif
      if (fsr_wr) fsr <= data_bus_i;
    end
  end

  // Core write is issued last so it overrides a same-edge peripheral write.
  always_ff @(posedge clk) begin
    if (!run) begin
      mem[clr_cnt] <= '0;
    end else begin
      for (int ii = 0; ii < NUM_EXPOSED_REGS; ii++) begin
        if (ext_wr[ii]) mem[IDXW'(EXPOSED_BASE + ii)] <= ext_data[ii*DWIDTH +: DWIDTH];
      end
      if (core_wr) mem[phys_idx] <= data_bus_i;
    end
  end

  for (genvar gi = 0; gi < NUM_EXPOSED_REGS; gi++) begin : g_exposed
    assign exposed_reg_file[gi*DWIDTH +: DWIDTH] = mem[EXPOSED_BASE + gi];
  end
endmodule

// File: tb/tb_reg_file_banked.sv
// tb/tb_reg_file_banked.sv - randomized bench with behavioural model for reg_file_banked
module tb_reg_file_banked;
  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [4:0]  addr = '0;
  logic [0:0]  bank_i = '0;
  logic [7:0]  data_bus_i = '0;
  logic        rden = 1'b0;
  logic        wren = 1'b0;
  logic [7:0]  data_bus_o;
  logic        rd_valid;
  logic        busy;
  logic [3:0]  ext_wr = '0;
  logic [31:0] ext_data = '0;
  logic [3:0]  exposed_wr_strobe;
  logic [31:0] exposed_reg_file;

  int checks = 0;
  int failures = 0;
  bit started = 1'b0;

  reg_file_banked dut (
    .clk(clk), .rst(rst), .addr(addr), .bank_i(bank_i), .data_bus_i(data_bus_i),
    .rden(rden), .wren(wren), .data_bus_o(data_bus_o), .rd_valid(rd_valid), .busy(busy),
    .ext_wr(ext_wr), .ext_data(ext_data), .exposed_wr_strobe(exposed_wr_strobe),
    .exposed_reg_file(exposed_reg_file)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Behavioural model: plain arrays indexed bank*32+addr, FSR as an integer.
  int         mmem [64];
  int         mfsr = 0;
  int         clear_left = 64;
  logic [7:0] e_data = '0;
  logic       e_valid = 1'b0;
  logic [3:0] e_strobe = '0;

  always @(posedge clk or negedge rst) begin
    int a, b, idx, rv, nf;
    bit ind, self_t;
    if (!rst) begin
      clear_left = 64; mfsr = 0; e_data = '0; e_valid = 1'b0; e_strobe = '0;
    end else if (clear_left > 0) begin
      clear_left--;
      e_valid = 1'b0; e_strobe = '0;
      if (clear_left == 0) for (int i = 0; i < 64; i++) mmem[i] = 0;
    end else begin
      ind = (addr == 5'd0);
      if (ind) begin a = mfsr % 32; b = (mfsr / 32) % 2; end
      else     begin a = int'(addr); b = int'(bank_i); end
      if (a < 16) b = 0;
      self_t = ind && (a == 0);
      idx = b * 32 + a;
      rv = self_t ? 0 : ((idx == 4) ? mfsr : mmem[idx]);
      e_valid = rden;
      if (rden) e_data = rv[7:0];
      e_strobe = '0;
      for (int i = 0; i < 4; i++) if (ext_wr[i]) mmem[16 + i] = int'(ext_data[i*8 +: 8]);
      nf = mfsr;
`ifdef REG_FILE_FSR_POSTINC_EN
      if (ind && (rden || wren)) nf = (mfsr + 1) % 64;
`endif
      if (wren && !self_t) begin
        if (idx == 4) nf = int'(data_bus_i);
        else          mmem[idx] = int'(data_bus_i);
        if (b == 0 && a >= 16 && a < 20) e_strobe[a - 16] = 1'b1;
      end
      mfsr = nf;
    end
  end

  always @(negedge clk) begin
    logic [31:0] ee;
    if (started) begin
      chk("busy", busy, clear_left > 0);
      chk("rd_valid", rd_valid, e_valid);
      chk("data_bus_o", data_bus_o, e_data);
      chk("strobe", exposed_wr_strobe, e_strobe);
      if (clear_left == 0) begin
        for (int i = 0; i < 4; i++) ee[i*8 +: 8] = mmem[16 + i][7:0];
        chk("exposed_reg_file", exposed_reg_file, ee);
      end
    end
  end

  task automatic op(input logic r, input logic w, input logic [0:0] b, input logic [4:0] a,
                    input logic [7:0] d, input logic [3:0] ew, input logic [31:0] ed);
    @(negedge clk);
    rden = r; wren = w; bank_i = b; addr = a; data_bus_i = d; ext_wr = ew; ext_data = ed;
    @(posedge clk);
    #1;
    rden = 1'b0; wren = 1'b0; ext_wr = '0;
  endtask

  task automatic count_busy(output int n);
    n = 0;
    while (busy === 1'b1 && n < 200) begin
      @(posedge clk);
      #1;
      n++;
    end
  endtask

  task automatic read_all_zero();
    for (int b = 0; b < 2; b++)
      for (int a = 1; a < 32; a++) begin
        op(1'b1, 1'b0, b[0:0], a[4:0], 8'h00, 4'h0, 32'h0);
        chk("sweep_zero", data_bus_o, 32'h0);
      end
  endtask

  logic [4:0] rand_addr;
  int         n;
  logic [7:0] exp_fsr;

  initial begin
    repeat (3) @(posedge clk);
    #2 rst = 1'b1;
    started = 1'b1;
    count_busy(n);
    chk("busy_cycles_first", n, 64);
    read_all_zero();

    op(1'b0, 1'b1, 1'b1, 5'h18, 8'hA5, 4'h0, 32'h0);
    op(1'b1, 1'b0, 1'b0, 5'h18, 8'h00, 4'h0, 32'h0);
    chk("bank0_0x18", data_bus_o, 32'h00);
    op(1'b1, 1'b0, 1'b1, 5'h18, 8'h00, 4'h0, 32'h0);
    chk("bank1_0x18", data_bus_o, 32'hA5);
    chk("bank1_0x18_valid", rd_valid, 32'h1);

    op(1'b0, 1'b1, 1'b1, 5'h05, 8'h3C, 4'h0, 32'h0);
    op(1'b1, 1'b0, 1'b0, 5'h05, 8'h00, 4'h0, 32'h0);
    chk("shared_0x05", data_bus_o, 32'h3C);

    op(1'b0, 1'b1, 1'b0, 5'h04, 8'h31, 4'h0, 32'h0);
    op(1'b0, 1'b1, 1'b0, 5'h00, 8'h77, 4'h0, 32'h0);
    op(1'b1, 1'b0, 1'b1, 5'h11, 8'h00, 4'h0, 32'h0);
    chk("indf_write_b1_0x11", data_bus_o, 32'h77);
    op(1'b0, 1'b1, 1'b0, 5'h04, 8'h00, 4'h0, 32'h0);
    op(1'b1, 1'b0, 1'b0, 5'h00, 8'h00, 4'h0, 32'h0);
    chk("indf_self_read", data_bus_o, 32'h00);
    chk("indf_self_valid", rd_valid, 32'h1);
    op(1'b0, 1'b1, 1'b0, 5'h04, 8'h3F, 4'h0, 32'h0);
    op(1'b1, 1'b0, 1'b0, 5'h00, 8'h00, 4'h0, 32'h0);
`ifdef REG_FILE_FSR_POSTINC_EN
    exp_fsr = 8'h00;
`else
    exp_fsr = 8'h3F;
`endif
    op(1'b1, 1'b0, 1'b0, 5'h04, 8'h00, 4'h0, 32'h0);
    chk("fsr_after_indf", data_bus_o, {24'h0, exp_fsr});

    op(1'b0, 1'b1, 1'b0, 5'h10, 8'h55, 4'b0001, 32'h0000_00AA);
    chk("core_wins_exp0", exposed_reg_file[7:0], 32'h55);
    chk("core_strobe0", exposed_wr_strobe, 32'h1);
    op(1'b0, 1'b0, 1'b0, 5'h01, 8'h00, 4'b0010, 32'h0000_1200);
    chk("ext_exp1", exposed_reg_file[15:8], 32'h12);
    chk("ext_no_strobe", exposed_wr_strobe, 32'h0);

    for (int i = 0; i < 3000; i++) begin
      rand_addr = 5'($urandom_range(0, 31));
      if ($urandom_range(0, 3) == 0) begin
        case ($urandom_range(0, 5))
          0: rand_addr = 5'd0;
          1: rand_addr = 5'd4;
          default: rand_addr = 5'(16 + $urandom_range(0, 3));
        endcase
      end
      op(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
         rand_addr, 8'($urandom), ($urandom_range(0, 5) == 0) ? 4'($urandom) : 4'h0,
         32'($urandom));
    end

    op(1'b1, 1'b0, 1'b1, 5'h18, 8'h00, 4'h0, 32'h0);
    chk("pre_reset_valid", rd_valid, 32'h1);
    #2 rst = 1'b0;
    #1;
    chk("reset_rd_valid", rd_valid, 32'h0);
    chk("reset_data", data_bus_o, 32'h0);
    chk("reset_busy", busy, 32'h1);
    repeat (2) @(posedge clk);
    #2 rst = 1'b1;
    count_busy(n);
    chk("busy_cycles_after_read_reset", n, 64);
    op(1'b1, 1'b0, 1'b0, 5'h04, 8'h00, 4'h0, 32'h0);
    chk("fsr_reset", data_bus_o, 32'h0);

    for (int i = 0; i < 40; i++)
      op(1'b0, 1'b1, 1'($urandom_range(0, 1)), 5'($urandom_range(1, 31)), 8'($urandom | 1),
         4'h0, 32'h0);
    @(posedge clk);
    #2 rst = 1'b0;
    @(posedge clk);
    #2 rst = 1'b1;
    repeat (10) @(posedge clk);
    #2 rst = 1'b0;
    #1 chk("midsweep_busy", busy, 32'h1);
    repeat (2) @(posedge clk);
    #2 rst = 1'b1;
    count_busy(n);
    chk("busy_cycles_after_midsweep", n, 64);
    read_all_zero();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog timeout checks=%0d", checks);
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/reg_file_banked.md
Name: reg_file_banked

Overview:
- Parametrised successor to the single-bank PIC file register.
- Adds bank-switched storage, a shared low region, a post-reset clearing sweep, registered read with valid strobe, and per-register write strobes for exposed registers.
- Adds a peripheral-side update port so GPIO and timer logic can load exposed registers.
- Sits between the core datapath (addr/data bus) and the peripherals.

Parameters:
- DWIDTH, 8, data width.
- NUM_FREGS, 32, registers per bank (power of 2).
- L2_NUM_FREG, 5, log2(NUM_FREGS).
- NUM_BANKS, 2, bank count (power of 2, >=1).
- L2_NUM_BANKS, 1, log2(NUM_BANKS) (max(1,...) when NUM_BANKS=1).
- NUM_SHARED, 16, low addresses 0..NUM_SHARED-1 always map to bank 0.
- NUM_EXPOSED_REGS, 4, exposed registers at bank-0 addresses 16..16+N-1.
- INDF_REG_ADDR, 0, indirect-access address.
- FSR_REG_ADDR, 4, FSR address (bank 0, shared).

Ports:
- clk  in  1  clock.
- rst  in  1  reset.
- addr  in  L2_NUM_FREG  direct address.
- bank_i  in  L2_NUM_BANKS  bank for direct access.
- data_bus_i  in  DWIDTH  write data.
- rden  in  1  read request.
- wren  in  1  write request.
- data_bus_o  out  DWIDTH  read data.
- rd_valid  out  1  read data valid pulse.
- busy  out  1  clearing sweep in progress; requests ignored.
- ext_wr  in  NUM_EXPOSED_REGS  peripheral write enables, one per exposed register.
- ext_data  in  DWIDTH*NUM_EXPOSED_REGS  peripheral write data, packed.
- exposed_wr_strobe  out  NUM_EXPOSED_REGS  core-write pulse per exposed register.
- exposed_reg_file  out  DWIDTH*NUM_EXPOSED_REGS  exposed register contents, packed; register ii at bits [(ii+1)*DWIDTH-1 -: DWIDTH].

Interface: one clock; reset is asynchronous and active-low.

Behaviour:
- Physical array is NUM_BANKS*NUM_FREGS entries; index = {bank, addr}.
- Effective bank is 0 when addr < NUM_SHARED, otherwise bank_i.
- Indirect access (addr==INDF_REG_ADDR): the FSR low L2_NUM_FREG bits give the address. Next L2_NUM_BANKS FSR bits give the bank; the shared-region rule applies to the resulting address.
- Indirect access whose target is INDF_REG_ADDR: reads return 0, writes are discarded.
- Reset (rst low, async):
  - FSR=0, data_bus_o=0, rd_valid=0, exposed_wr_strobe=0, busy=1.
  - FSM enters CLEAR with sweep counter 0.
- FSM CLEAR:
  - Writes 0 to entry[counter] each cycle and increments the counter.
  - After entry NUM_BANKS*NUM_FREGS-1, moves to RUN and busy drops the next cycle.
  - Total busy = NUM_BANKS*NUM_FREGS cycles after reset release.
  - rden, wren and ext_wr are ignored while busy.
- FSM RUN:
  - Read: rden sampled at edge N gives data_bus_o and rd_valid=1 after edge N; rd_valid lasts one cycle.
  - data_bus_o holds its last value when no read occurs.
  - Read and write to the same entry in the same cycle returns the old data.
- Exposed registers:
  - Core write to an exposed register pulses exposed_wr_strobe[ii] for one cycle, coincident with the updated exposed_reg_file.
  - ext_wr[ii] writes ext_data slice ii the same edge and produces no strobe.
  - Core write and ext_wr to the same register in the same cycle: core wins, ext write is dropped.
- Reset asserted mid-sweep or mid-access: restarts CLEAR from 0 and aborts any pending read (rd_valid=0).
- Out-of-range bank_i is impossible because the array is sized to a power of 2.

Optional Feature:
- Macro: REG_FILE_FSR_POSTINC_EN.
- Defined: every accepted INDF access (rden or wren) post-increments FSR at the same edge. The increment is modulo 2^(L2_NUM_FREG+L2_NUM_BANKS) and wraps to 0. A same-cycle core write to FSR takes precedence over the increment.
- Undefined: FSR changes only by explicit write.

Decomposition:
- Shared package pic_params holds:
  - DWIDTH, NUM_FREGS, L2_NUM_FREG, NUM_BANKS, L2_NUM_BANKS, NUM_SHARED.
  - INDF/FSR addresses and exposed base address 16.
  - FSM state encoding (CLEAR, RUN).
- Sub-module reg_file_addr_map: combinational; takes addr, bank_i and FSR, and produces the physical index plus flags is_indf_self and exposed_hit with its index.

Test Plan:
1. Release reset -> busy=1 for 64 cycles (2x32) with writes ignored; afterwards every entry reads 0.
2. bank_i=1, write 0xA5 to addr 0x18; bank_i=0, read 0x18 -> 0x00; bank_i=1, read 0x18 -> 0xA5 with rd_valid one cycle later.
3. bank_i=1, write 0x3C to addr 0x05 (shared); bank_i=0, read 0x05 -> 0x3C.
4. FSR=0x31, write 0x77 to INDF -> entry bank1/addr0x11 = 0x77. FSR=0x00, read INDF -> 0x00, no entry modified. With REG_FILE_FSR_POSTINC_EN: FSR=0x3F, INDF access -> FSR=0x00.
5. Core writes 0x55 to addr 16 while ext_wr[0] writes 0xAA -> exposed reg 0 = 0x55 and exposed_wr_strobe[0] pulses once. ext_wr[1] alone with 0x12 -> exposed reg 1 = 0x12, no strobe.
6. Assert rst mid-sweep at cycle 10 and mid-read -> rd_valid=0, FSR=0, sweep restarts, busy remains high for a full 64 cycles after release.
